// File: rtl/filter_pkg.sv
// filter_pkg: shared mode/state encodings and constants for filter_mode_sequencer
package filter_pkg;
  typedef enum logic [3:0] {
    PASS        = 4'd0,
    GRAY        = 4'd1,
    INVERT      = 4'd2,
    THRESH      = 4'd3,
    BLUR        = 4'd4,
    SHARPEN     = 4'd5,
    EDGE_H      = 4'd6,
    EDGE_V      = 4'd7,
    SOBEL       = 4'd8,
    EMBOSS      = 4'd9,
    BLUR_RGB    = 4'd10,
    SHARPEN_RGB = 4'd11
  } mode_e;
  typedef enum logic [1:0] {WAIT_SYNC, ACTIVE, VBLANK} state_e;
  localparam int NUM_MODES = 12;
  localparam int KERNEL_RADIUS = 1;
  function automatic logic [3:0] clamp_mode(input logic [3:0] m);
    return m > 4'(NUM_MODES - 1) ? PASS : m;
  endfunction
  function automatic logic [3:0] next_mode(input logic [3:0] m);
    return m >= 4'(NUM_MODES - 1) ? PASS : m + 4'd1;
  endfunction
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: single-cycle rise/fall pulses from comparing a sync input with its previous value
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic prev;
  always_ff @(posedge clk) prev <= rst ? 1'b0 : d;
  assign rise = d & ~prev;
  assign fall = ~d & prev;
endmodule

// File: rtl/filter_mode_sequencer.sv
// filter_mode_sequencer: follows VGA timing, latches the filter mode at frame boundaries, reports pixel position.
// Define FILTER_AUTOCYCLE_EN to ignore req_mode and step through all modes every CYCLE_FRAMES frames.
module filter_mode_sequencer
  import filter_pkg::*;
#(
  parameter int WIDTH        = 800,
  parameter int HEIGHT       = 480,
  parameter int CYCLE_FRAMES = 120
) (
  input  logic       VGA_CLK,
  input  logic       reset,
  input  logic       iVGA_HS,
  input  logic       iVGA_VS,
  input  logic       iVGA_BLANK_N,
  input  logic [3:0] req_mode,
  output logic [3:0] active_mode,
  output logic       mode_changed,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       border,
  output logic       frame_start
);
  localparam logic [9:0] X_MAX = 10'(WIDTH - 1);
  localparam logic [9:0] Y_MAX = 10'(HEIGHT - 1);
  state_e state, state_n;
  logic hs_rise, hs_fall, vs_rise, vs_fall, blank_rise, blank_fall, unused_rise;
  logic live, border_n;
  logic [9:0] x_n, y_n;
  logic [3:0] mode_n;

  sync_edge_detect u_hs (.clk(VGA_CLK), .rst(reset), .d(iVGA_HS), .rise(hs_rise), .fall(hs_fall));
  sync_edge_detect u_vs (.clk(VGA_CLK), .rst(reset), .d(iVGA_VS), .rise(vs_rise), .fall(vs_fall));
  sync_edge_detect u_blank (.clk(VGA_CLK), .rst(reset), .d(iVGA_BLANK_N), .rise(blank_rise), .fall(blank_fall));
  assign unused_rise = hs_rise ^ vs_rise;

`ifdef FILTER_AUTOCYCLE_EN
  logic [15:0] frames;
  logic unused_req;
  assign unused_req = ^req_mode;
  always_ff @(posedge VGA_CLK)
    if (reset) frames <= '0;
    else if (vs_fall) frames <= (frames == 16'(CYCLE_FRAMES - 1)) ? '0 : frames + 16'd1;
  assign mode_n = (vs_fall && frames == 16'(CYCLE_FRAMES - 1)) ? next_mode(active_mode) : active_mode;
`else
  logic [3:0] pending;
  always_ff @(posedge VGA_CLK) pending <= reset ? PASS : clamp_mode(req_mode);
  assign mode_n = vs_fall ? pending : active_mode;
`endif

  always_ff @(posedge VGA_CLK)
    if (reset) begin
      state        <= WAIT_SYNC;
      active_mode  <= PASS;
      mode_changed <= 1'b0;
      pix_x        <= '0;
      pix_y        <= '0;
      border       <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      state        <= state_n;
      active_mode  <= mode_n;
      mode_changed <= mode_n != active_mode;
      pix_x        <= x_n;
      pix_y        <= y_n;
      border       <= border_n;
      frame_start  <= vs_fall;
    end

  always_comb state_n = vs_fall ? VBLANK : (state == VBLANK && blank_rise) ? ACTIVE : state;

  // The first visible pixel of a line keeps column 0, so pix_x always names the pixel just presented.
  always_comb begin
    live     = state != WAIT_SYNC;
    x_n      = hs_fall ? '0 : (live && iVGA_BLANK_N && !blank_rise && pix_x != X_MAX) ? pix_x + 10'd1 : pix_x;
    y_n      = vs_fall ? '0 : (state == ACTIVE && blank_fall && pix_y != Y_MAX) ? pix_y + 10'd1 : pix_y;
    border_n = live && iVGA_BLANK_N && (x_n == '0 || x_n == X_MAX || y_n == '0 || y_n == Y_MAX);
  end
endmodule

// File: doc/filter_mode_sequencer.md
FILTER_MODE_SEQUENCER -- requirements
Module: filter_mode_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 800, active pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 480, active lines per frame.
REQ-003 SHALL have parameter CYCLE_FRAMES, default 120, frames per mode in auto-cycle.
REQ-004 SHALL have port VGA_CLK  in  1  sole clock, 25 MHz.
REQ-005 SHALL have port reset  in  1  reset; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port iVGA_HS  in  1  horizontal sync, low between lines.
REQ-007 SHALL have port iVGA_VS  in  1  vertical sync, low between frames.
REQ-008 SHALL have port iVGA_BLANK_N  in  1  high during visible pixels.
REQ-009 SHALL have port req_mode  in  4  requested filter mode (from SW[3:0]).
REQ-010 SHALL have port active_mode  out  4  mode applied to the current frame.
REQ-011 SHALL have port mode_changed  out  1  one-cycle pulse when active_mode updates.
REQ-012 SHALL have port pix_x  out  10  column of the current visible pixel.
REQ-013 SHALL have port pix_y  out  10  row of the current visible pixel.
REQ-014 SHALL have port border  out  1  high when the 3x3 window is incomplete at the current pixel.
REQ-015 SHALL have port frame_start  out  1  one-cycle pulse on the iVGA_VS falling edge.

Function
REQ-016 SHALL register all outputs; every output lags its causing input edge by exactly 1 VGA_CLK.
REQ-017 SHALL detect edges by comparing each sync input with its value on the previous cycle.
REQ-018 SHALL implement states WAIT_SYNC, ACTIVE and VBLANK.
REQ-019 WAIT_SYNC SHALL go to VBLANK on the first iVGA_VS falling edge; outputs stay at reset values until then.
REQ-020 VBLANK SHALL go to ACTIVE on the first iVGA_BLANK_N rising edge.
REQ-021 ACTIVE SHALL go to VBLANK on an iVGA_VS falling edge.
REQ-022 SHALL sample req_mode every cycle into a pending register.
REQ-023 SHALL copy pending to active_mode only on an iVGA_VS falling edge, so the mode never changes mid-frame.
REQ-024 SHALL map a pending value above 11 to 0 (passthrough).
REQ-025 SHALL pulse mode_changed only when the newly applied value differs from the old one.
REQ-026 pix_x SHALL reset to 0 on an iVGA_HS falling edge.
REQ-027 pix_x SHALL increment on each cycle iVGA_BLANK_N is high and saturate at WIDTH-1.
REQ-028 pix_y SHALL increment on an iVGA_BLANK_N falling edge while in ACTIVE, saturate at HEIGHT-1, and reset to 0 on an iVGA_VS falling edge.
REQ-029 border SHALL equal (pix_x==0 | pix_x==WIDTH-1 | pix_y==0 | pix_y==HEIGHT-1) while iVGA_BLANK_N is high, and 0 otherwise.
REQ-030 On simultaneous HS and VS falling edges, both counters SHALL clear and the mode update SHALL apply in the same cycle.

Reset
REQ-031 reset SHALL force: state WAIT_SYNC; active_mode, pending, pix_x, pix_y all 0; border, mode_changed, frame_start all 0.
REQ-032 reset asserted mid-frame SHALL abandon the frame; the block resumes only after the next iVGA_VS falling edge.

Configuration
REQ-033 With FILTER_AUTOCYCLE_EN defined, req_mode SHALL be ignored; a frame counter SHALL advance active_mode by 1 at the VS falling edge after each CYCLE_FRAMES frames, wrapping 11 to 0.
REQ-034 Without FILTER_AUTOCYCLE_EN, the frame counter SHALL be absent and modes SHALL follow REQ-022 to REQ-025.

Structure
REQ-035 Shared package filter_pkg SHALL hold: the mode enum (PASS=0, GRAY=1 ... SHARPEN_RGB=11), NUM_MODES=12, the state enum, and KERNEL_RADIUS=1.
REQ-036 SHALL instantiate one sub-module, sync_edge_detect, per sync input (rise/fall pulse outputs).

Verification
REQ-037 Scenario: reset, then req_mode=5 applied mid-frame -> active_mode stays 0 until the next VS falling edge, then becomes 5 with one mode_changed pulse.
REQ-038 Scenario: req_mode=14 -> at the next frame, active_mode=0 and no mode_changed pulse is issued if it was already 0.
REQ-039 Scenario: an 802-cycle BLANK_N-high line -> pix_x reaches 799 and holds; border is high at pix_x=0 and at 799.
REQ-040 Scenario: a 481-line frame -> pix_y saturates at 479; the VS falling edge produces pix_y=0 and frame_start=1 one cycle later.
REQ-041 Scenario: reset asserted at pixel (400,200) -> all outputs 0 next cycle; no border or counting occurs until after the next VS falling edge.
REQ-042 Scenario: FILTER_AUTOCYCLE_EN defined with CYCLE_FRAMES=2 -> active_mode steps 0,1,...,11,0 every 2 frames.
